// File: rtl/control_pipe.sv
// control_pipe: carries decoded control bits from ID through EX, MEM and WB,
// detects load-use hazards against the instruction in EX, and inserts a
// single-cycle bubble on a stall or a taken branch.
// Optional stall-cycle counter is enabled by defining CONTROL_PIPE_STALL_CNT_EN.
module control_pipe (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  ctrl_id,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        branch_taken,
    output logic [3:0]  ex_ctrl,
    output logic [1:0]  mem_ctrl,
    output logic [1:0]  wb_ctrl,
    output logic [4:0]  ex_rt,
    output logic        stall,
    output logic [15:0] stall_count
);

    // Bit positions inside the 8-bit control bundle
    localparam int MEM_READ_BIT = 6;

    // ID/EX stage
    logic [7:0] idex_ctrl_q, idex_ctrl_d;
    logic [4:0] idex_rt_q,   idex_rt_d;
    // EX/MEM stage: {MemWrite, MemRead} and {MemToReg, RegWrite}
    logic [1:0] exmem_mem_q, exmem_mem_d;
    logic [1:0] exmem_wb_q,  exmem_wb_d;
    // MEM/WB stage: {MemToReg, RegWrite}
    logic [1:0] memwb_wb_q,  memwb_wb_d;

    logic hazard;
    logic bubble;

    // Load-use detection and stall qualification; a taken branch or reset wins
    always_comb begin
        hazard = idex_ctrl_q[MEM_READ_BIT] && (idex_rt_q != 5'd0) &&
                 ((idex_rt_q == id_rs) || (idex_rt_q == id_rt));
        stall  = hazard && !branch_taken && reset;
        bubble = stall || branch_taken;
    end

    // Next-state for every stage; only ID/EX can be replaced by a bubble
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        idex_ctrl_d = ctrl_id;
        idex_rt_d   = id_rt;
        if (bubble) begin
            idex_ctrl_d = 8'h00;
            idex_rt_d   = 5'd0;
        end
        exmem_mem_d = idex_ctrl_q[7:6];
        exmem_wb_d  = idex_ctrl_q[5:4];
        memwb_wb_d  = exmem_wb_q;
    end

    // Stage registers with synchronous active-low clear
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all stages update from pre-edge values.
        if (!reset) begin
            idex_ctrl_q <= 8'h00;
            idex_rt_q   <= 5'd0;
            exmem_mem_q <= 2'b00;
            exmem_wb_q  <= 2'b00;
            memwb_wb_q  <= 2'b00;
        end else begin
            idex_ctrl_q <= idex_ctrl_d;
            idex_rt_q   <= idex_rt_d;
            exmem_mem_q <= exmem_mem_d;
            exmem_wb_q  <= exmem_wb_d;
            memwb_wb_q  <= memwb_wb_d;
        end
    end

`ifdef CONTROL_PIPE_STALL_CNT_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    // Saturating stall-cycle count
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    // Counter register, cleared with the pipeline
    always_ff @(posedge clk) begin
        if (!reset) begin
            stall_cnt_q <= 16'h0000;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_count = stall_cnt_q;
`else
    assign stall_count = 16'h0000;
`endif

    assign ex_ctrl  = idex_ctrl_q[3:0];
    assign ex_rt    = idex_rt_q;
    assign mem_ctrl = exmem_mem_q;
    assign wb_ctrl  = memwb_wb_q;

endmodule

// File: tb/tb_control_pipe.sv
// Directed testbench for control_pipe: straight flow, load-use stall,
// $zero hazard, flush-beats-stall, mid-stream reset and (with the counter
// macro) saturation of the stall counter.
module tb_control_pipe;

`ifdef CONTROL_PIPE_STALL_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic [7:0]  ctrl_id;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic        branch_taken;
    logic [3:0]  ex_ctrl;
    logic [1:0]  mem_ctrl;
    logic [1:0]  wb_ctrl;
    logic [4:0]  ex_rt;
    logic        stall;
    logic [15:0] stall_count;

    int passed = 0;
    int total  = 0;

    control_pipe dut (
        .clk          (clk),
        .reset        (reset),
        .ctrl_id      (ctrl_id),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .branch_taken (branch_taken),
        .ex_ctrl      (ex_ctrl),
        .mem_ctrl     (mem_ctrl),
        .wb_ctrl      (wb_ctrl),
        .ex_rt        (ex_rt),
        .stall        (stall),
        .stall_count  (stall_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    // Advance one rising edge and sample 1 time unit later
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [7:0] c, input logic [4:0] rs, input logic [4:0] rt);
        ctrl_id = c;
        id_rs   = rs;
        id_rt   = rt;
        #1;
    endtask

    task automatic check_outs(input string tag, input logic [3:0] ex, input logic [1:0] mem,
                              input logic [1:0] wb, input logic [4:0] rt);
        check({tag, ".ex_ctrl"},  {12'h0, ex_ctrl},  {12'h0, ex});
        check({tag, ".mem_ctrl"}, {14'h0, mem_ctrl}, {14'h0, mem});
        check({tag, ".wb_ctrl"},  {14'h0, wb_ctrl},  {14'h0, wb});
        check({tag, ".ex_rt"},    {11'h0, ex_rt},    {11'h0, rt});
    endtask

    initial begin
        reset = 1'b0;
        branch_taken = 1'b0;
        drive(8'h00, 5'd0, 5'd0);
        tick();
        tick();
        check_outs("reset", 4'h0, 2'b00, 2'b00, 5'd0);
        check("reset.stall", {15'h0, stall}, 16'h0);
        check("reset.count", stall_count, 16'h0);

        // Straight flow: 5A (a load to rt=3), 3C, 81; no dependency on rt=3
        reset = 1'b1;
        drive(8'h5A, 5'd0, 5'd3);
        tick();
        check_outs("flow1", 4'hA, 2'b00, 2'b00, 5'd3);
        drive(8'h3C, 5'd1, 5'd2);
        check("flow1.stall", {15'h0, stall}, 16'h0);
        tick();
        check_outs("flow2", 4'hC, 2'b01, 2'b00, 5'd2);
        drive(8'h81, 5'd4, 5'd6);
        check("flow2.stall", {15'h0, stall}, 16'h0);
        tick();
        check_outs("flow3", 4'h1, 2'b00, 2'b01, 5'd6);
        drive(8'h00, 5'd0, 5'd0);
        tick();
        check_outs("flow4", 4'h0, 2'b10, 2'b11, 5'd0);
        tick();
        check_outs("flow5", 4'h0, 2'b00, 2'b00, 5'd0);

        // Load-use: lw (ctrl 73) rt=5, then dependent (ctrl 12) with rs=5
        drive(8'h73, 5'd0, 5'd5);
        check("lu.pre_stall", {15'h0, stall}, 16'h0);
        tick();
        check_outs("lu.lw_in_ex", 4'h3, 2'b00, 2'b00, 5'd5);
        drive(8'h12, 5'd5, 5'd7);
        check("lu.stall", {15'h0, stall}, 16'h1);
        tick();
        check_outs("lu.bubble", 4'h0, 2'b01, 2'b00, 5'd0);
        check("lu.stall_cleared", {15'h0, stall}, 16'h0);
        check("lu.count", stall_count, CNT_EN ? 16'd1 : 16'd0);
        tick();
        check_outs("lu.dep_in_ex", 4'h2, 2'b00, 2'b11, 5'd7);
        drive(8'h00, 5'd0, 5'd0);
        tick();
        check_outs("lu.drain", 4'h0, 2'b00, 2'b00, 5'd0);

        // Load to $zero never stalls
        drive(8'h40, 5'd0, 5'd0);
        tick();
        drive(8'h01, 5'd0, 5'd0);
        check("zero.stall", {15'h0, stall}, 16'h0);
        tick();
        check_outs("zero.next", 4'h1, 2'b01, 2'b00, 5'd0);

        // Flush beats stall
        drive(8'h40, 5'd0, 5'd9);
        tick();
        drive(8'h0F, 5'd9, 5'd1);
        check("flush.hazard_alone", {15'h0, stall}, 16'h1);
        branch_taken = 1'b1;
        #1;
        check("flush.stall", {15'h0, stall}, 16'h0);
        tick();
        check_outs("flush.bubble", 4'h0, 2'b01, 2'b00, 5'd0);
        check("flush.count", stall_count, CNT_EN ? 16'd1 : 16'd0);
        branch_taken = 1'b0;
        drive(8'h00, 5'd0, 5'd0);
        tick();
        tick();

        // Mid-stream reset with a live hazard
        drive(8'h73, 5'd0, 5'd4);
        tick();
        drive(8'h05, 5'd4, 5'd0);
        check("mreset.hazard", {15'h0, stall}, 16'h1);
        reset = 1'b0;
        #1;
        check("mreset.stall", {15'h0, stall}, 16'h0);
        tick();
        check_outs("mreset.cleared", 4'h0, 2'b00, 2'b00, 5'd0);
        check("mreset.count", stall_count, 16'h0);
        reset = 1'b1;
        drive(8'h3C, 5'd0, 5'd1);
        tick();
        check_outs("mreset.resume", 4'hC, 2'b00, 2'b00, 5'd1);

`ifdef CONTROL_PIPE_STALL_CNT_EN
        // Saturation: preload near the top, then force two more stalls
        drive(8'h00, 5'd0, 5'd0);
        tick();
        force dut.stall_cnt_q = 16'hFFFE;
        #1;
        release dut.stall_cnt_q;
        for (int i = 0; i < 2; i++) begin
            drive(8'h40, 5'd0, 5'd5);
            tick();
            drive(8'h00, 5'd5, 5'd0);
            check("sat.stall", {15'h0, stall}, 16'h1);
            tick();
        end
        check("sat.count", stall_count, 16'hFFFF);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/control_pipe.md
CONTROL_PIPE -- requirements
Module: control_pipe

Interface
REQ-001 clk  input  1  single clock; all state updates on its rising edge.
REQ-002 reset  input  1  synchronous, active-low reset; sampled only on the rising edge of clk.
REQ-003 ctrl_id  input  8  decoded control bundle from the controller in ID: [3:0]=EX {RegDst, ALUSrc, ALUOp[1:0]}, [5:4]=WB {MemToReg, RegWrite}, [7:6]=MEM {MemWrite, MemRead}.
REQ-004 id_rs  input  5  rs field of the instruction in ID.
REQ-005 id_rt  input  5  rt field of the instruction in ID.
REQ-006 branch_taken  input  1  branch/jump resolved taken in ID; squash the ID instruction.
REQ-007 ex_ctrl  output  4  EX fields of the instruction now in EX.
REQ-008 mem_ctrl  output  2  MEM fields of the instruction now in MEM, bit0=MemRead, bit1=MemWrite.
REQ-009 wb_ctrl  output  2  WB fields of the instruction now in WB, bit0=RegWrite, bit1=MemToReg.
REQ-010 ex_rt  output  5  rt of the instruction in EX, for the forwarding unit.
REQ-011 stall  output  1  load-use hazard; PC and IF/ID hold when 1.
REQ-012 stall_count  output  16  saturating count of stall cycles (see Configuration).

Function
REQ-013 Three register stages SHALL exist: ID/EX {8-bit ctrl, 5-bit rt}, EX/MEM {MEM, WB}, MEM/WB {WB}.
REQ-014 Latency SHALL be fixed: ctrl_id sampled at edge n appears on ex_ctrl after edge n, on mem_ctrl after edge n+1, on wb_ctrl after edge n+2.
REQ-015 Hazard SHALL be: ID/EX MemRead=1 and ID/EX rt!=0 and (ID/EX rt==id_rs or ID/EX rt==id_rt).
REQ-016 stall SHALL equal hazard AND NOT branch_taken AND reset==1; it is purely combinational.
REQ-017 On stall=1, ID/EX SHALL load a bubble (all ctrl bits 0, rt=0); EX/MEM and MEM/WB advance normally.
REQ-018 On branch_taken=1, ID/EX SHALL load a bubble regardless of hazard (flush beats stall).
REQ-019 Otherwise ID/EX SHALL load {ctrl_id, id_rt}.
REQ-020 stall SHALL last exactly one cycle per load-use pair, because the bubble clears ID/EX MemRead.
REQ-021 EX/MEM and MEM/WB SHALL never stall or flush.
REQ-022 A bubble SHALL produce zero RegWrite, MemRead, and MemWrite at every downstream stage.

Reset
REQ-023 With reset=0 at an edge, all stage registers and stall_count SHALL clear to 0 on that edge.
REQ-024 After reset, ex_ctrl, mem_ctrl, wb_ctrl, and ex_rt SHALL read 0, and stall SHALL read 0.
REQ-025 stall SHALL be forced 0 while reset=0, including when reset is asserted mid-stream with a live hazard.
REQ-026 The first ctrl_id SHALL be captured on the first edge with reset=1.

Configuration
REQ-027 Macro CONTROL_PIPE_STALL_CNT_EN SHALL select the stall counter.
- Defined: stall_count increments by 1 on each edge where stall=1 and saturates at 16'hFFFF.
- Undefined: no counter register; stall_count is tied to 16'h0000.

Verification
REQ-028 Straight flow: reset, then ctrl_id=8'h5A, 8'h3C, 8'h81 on consecutive edges -> ex_ctrl=4'hA, 4'hC, 4'h1 one cycle later; mem_ctrl=2'b01 then 2'b00 then 2'b10 one cycle after that; wb_ctrl=2'b01 (from 8'h5A) the following cycle; stall never asserts.
REQ-029 Load-use: lw rt=5 (ctrl_id MemRead=1) followed by id_rs=5 -> stall=1 for exactly one cycle; ex_ctrl=0 on the next cycle; the dependent ctrl enters EX one cycle later; stall_count=1 when the macro is defined, 0 when not.
REQ-030 Hazard on $zero: lw rt=0 followed by id_rs=0 -> stall stays 0.
REQ-031 Flush beats stall: hazard condition true and branch_taken=1 in the same cycle -> stall=0, ID/EX bubble, and the next ex_ctrl=0.
REQ-032 Mid-stream reset: reset=0 while a lw is in EX and a hazard is pending -> stall=0 immediately; all outputs 0 after the edge; normal capture resumes on the first edge with reset=1.
REQ-033 Saturation (macro defined): force 65537 stall cycles -> stall_count holds 16'hFFFF.
